pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Combines four inputs into one consistent set of per-stage write-enable and bubble controls:
  - load-use hazard indication from hazard detection;
  - branch-taken resolution from EX;
  - multi-cycle mult/div busy;
  - data-memory wait.
- Sits between the hazard detection logic and the PC / IF-ID / ID-EX / EX-MEM / MEM-WB pipeline registers.
- Tracks multi-cycle stalls with an FSM, a memory-wait timeout and a stall-cycle counter.

Parameters:
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before forced abort
CNT_W, 16, width of stall-cycle performance counter
TO_W, 7, width of wait counter (must hold MEM_TIMEOUT)

Ports:
clk  input  1  pipeline clock
resetn  input  1  asynchronous active-low reset
iLoadUse  input  1  load-use hazard detected (ID/EX load, IF/ID consumer)
iBrTaken  input  1  branch/jump taken, resolved in EX
iMdStart  input  1  mult/div issued in EX this cycle
iMdDone  input  1  mult/div result ready
iDMemReq  input  1  MEM stage performing load/store
iDMemReady  input  1  data memory completes access this cycle
iCntClr  input  1  synchronous clear of oStallCnt and oTimeout
oPCWr  output  1  PC write enable (1 = advance/load)
oIFIDWr  output  1  IF/ID write enable
oIFIDFlush  output  1  IF/ID load NOP
oIDEXWr  output  1  ID/EX write enable
oIDEXBubble  output  1  ID/EX load NOP (control zeroed)
oEXMEMWr  output  1  EX/MEM write enable
oEXMEMBubble  output  1  EX/MEM load NOP
oMEMWBBubble  output  1  MEM/WB load NOP
oState  output  2  current FSM state (debug)
oStallCnt  output  CNT_W  saturating count of cycles with oPCWr=0
oTimeout  output  1  sticky: memory wait aborted on timeout

Behaviour:
- States: RUN=2'd0, MEM_WAIT=2'd1, MD_WAIT=2'd2. State, wait counter, oStallCnt and oTimeout use the async reset. The control outputs are a combinational decode of state and inputs, so they take effect in the same cycle.
- Reset: state=RUN, wait counter=0, oStallCnt=0, oTimeout=0. With all inputs low the RUN decode gives: all Wr=1, all Bubble/Flush=0, oState=0.
- RUN priority, highest first:
  1. Memory wait (iDMemReq & ~iDMemReady):
     - PC/IFID/IDEX/EXMEM Wr=0, oMEMWBBubble=1;
     - next=MEM_WAIT, wait counter=1.
  2. iMdStart & ~iMdDone:
     - PC/IFID/IDEX Wr=0, oEXMEMBubble=1;
     - next=MD_WAIT.
     - iMdStart & iMdDone in the same cycle: no stall, stay RUN.
  3. iBrTaken:
     - PCWr=1 (target load), oIFIDFlush=1, oIDEXBubble=1;
     - iLoadUse is ignored, because the branch kills the dependent instruction.
  4. iLoadUse: PCWr=0, IFIDWr=0, oIDEXBubble=1. One cycle only; no state change.
- MEM_WAIT:
  - Outputs held as in RUN case 1; wait counter increments each cycle.
  - iDMemReady=1: release decode (all Wr=1, oMEMWBBubble=0) in that cycle, next=RUN, counter=0.
  - Counter reaches MEM_TIMEOUT without ready: oTimeout<=1, oMEMWBBubble=1 this cycle, next=RUN.
- MD_WAIT:
  - Outputs held as in RUN case 2.
  - iMdDone=1: release (all Wr=1) in that cycle, next=RUN.
  - A memory wait arriving during MD_WAIT (iDMemReq & ~iDMemReady): next=MEM_WAIT. The MD result is held by the mult/div unit; afterwards the controller returns to RUN, and EX re-evaluates.
- Inputs are held stable by the frozen pipeline during waits. iBrTaken and iLoadUse are evaluated only in RUN.
- oStallCnt:
  - +1 on each cycle where oPCWr=0, saturating at all-ones.
  - iCntClr has priority over increment and also clears oTimeout.
- Unused state 2'd3 goes to RUN next cycle, with RUN decode.

Decomposition:
- Shared package/defines file (alongside RF_REG_W):
  - state encodings ST_RUN, ST_MEM_WAIT, ST_MD_WAIT;
  - default MEM_TIMEOUT;
  - CNT_W.
- Sub-module stall_counter: saturating counter with synchronous clear and async active-low reset. Instantiated for oStallCnt.
- FSM and output decode stay in pipe_stall_ctrl.

Test Plan:
- Reset: resetn=0 mid-MD_WAIT -> immediately oState=0, oPCWr=1, oStallCnt=0, oTimeout=0.
- Load-use: iLoadUse=1 one cycle -> oPCWr=0, oIFIDWr=0, oIDEXBubble=1 that cycle only; oStallCnt=1.
- Branch+load-use same cycle: iBrTaken=1, iLoadUse=1 -> oPCWr=1, oIFIDFlush=1, oIDEXBubble=1; oStallCnt unchanged.
- Memory wait:
  - iDMemReq=1, iDMemReady=0 for 5 cycles, then ready -> 5 frozen cycles with oMEMWBBubble=1, release on the 6th cycle;
  - oState goes 1 -> 0; oStallCnt=5.
- Timeout: MEM_TIMEOUT=4, ready never asserted -> oTimeout=1 after 4 wait cycles, return to RUN; iCntClr=1 clears both outputs.
- Mult/div:
  - iMdStart=1, iMdDone after 3 cycles -> oEXMEMBubble=1 during the wait, oState=2, release on the done cycle;
  - iMdStart with iMdDone in the same cycle -> no stall.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_stall_ctrl_pkg : shared pipeline widths, stall FSM encodings |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package pipe_stall_ctrl_pkg;

  localparam int RF_REG_W        = 5;
  localparam int MEM_TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF       = 16;
  localparam int TO_W_DEF        = 7;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MD_WAIT  = 2'd2,
    ST_RSVD     = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/pipe_stall_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_stall_ctrl_if : hazard inputs and per-stage pipeline controls|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface pipe_stall_ctrl_if
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             iLoadUse;
  logic             iBrTaken;
  logic             iMdStart;
  logic             iMdDone;
  logic             iDMemReq;
  logic             iDMemReady;
  logic             iCntClr;
  logic             oPCWr;
  logic             oIFIDWr;
  logic             oIFIDFlush;
  logic             oIDEXWr;
  logic             oIDEXBubble;
  logic             oEXMEMWr;
  logic             oEXMEMBubble;
  logic             oMEMWBBubble;
  logic [1:0]       oState;
  logic [CNT_W-1:0] oStallCnt;
  logic             oTimeout;

  modport master (
    output iLoadUse, iBrTaken, iMdStart, iMdDone, iDMemReq, iDMemReady, iCntClr,
    input  oPCWr, oIFIDWr, oIFIDFlush, oIDEXWr, oIDEXBubble, oEXMEMWr,
           oEXMEMBubble, oMEMWBBubble, oState, oStallCnt, oTimeout
  );

  modport slave (
    input  iLoadUse, iBrTaken, iMdStart, iMdDone, iDMemReq, iDMemReady, iCntClr,
    output oPCWr, oIFIDWr, oIFIDFlush, oIDEXWr, oIDEXBubble, oEXMEMWr,
           oEXMEMBubble, oMEMWBBubble, oState, oStallCnt, oTimeout
  );

endinterface
`default_nettype wire

// File: rtl/pipe_stall_ctrl_stall_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stall_counter : saturating up-counter, sync clear, async reset    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module stall_counter
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         clr_i,
  input  wire logic         inc_i,
  output logic      [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_stall_ctrl : 5-stage pipeline stall/flush sequencer          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TO_W        = TO_W_DEF
) (
  input  wire logic         clk,
  input  wire logic         resetn,
  pipe_stall_ctrl_if.slave  bus
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] WAIT_ONE = TO_W'(1);

  state_e           state_q, state_d;
  logic [TO_W-1:0]  wait_q, wait_d;
  logic             timeout_q, timeout_d;
  logic             abort;
  logic             mem_wait;
  logic             md_stall;
  logic             pc_wr, ifid_wr, ifid_flush, idex_wr, idex_bub;
  logic             exmem_wr, exmem_bub, memwb_bub;
  logic [CNT_W-1:0] stall_cnt;

  assign mem_wait = bus.iDMemReq & ~bus.iDMemReady;
  assign md_stall = bus.iMdStart & ~bus.iMdDone;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    abort      = 1'b0;
    pc_wr      = 1'b1;
    ifid_wr    = 1'b1;
    ifid_flush = 1'b0;
    idex_wr    = 1'b1;
    idex_bub   = 1'b0;
    exmem_wr   = 1'b1;
    exmem_bub  = 1'b0;
    memwb_bub  = 1'b0;
    case (state_q)
      ST_RUN, ST_RSVD: begin
        if (mem_wait) begin
          {pc_wr, ifid_wr, idex_wr, exmem_wr} = 4'b0000;
          memwb_bub = 1'b1;
          state_d   = ST_MEM_WAIT;
          wait_d    = WAIT_ONE;
        end else if (md_stall) begin
          {pc_wr, ifid_wr, idex_wr} = 3'b000;
          exmem_bub = 1'b1;
          state_d   = ST_MD_WAIT;
        end else if (bus.iBrTaken) begin
          // Branch squashes the dependent instruction, so load-use is moot.
          ifid_flush = 1'b1;
          idex_bub   = 1'b1;
        end else if (bus.iLoadUse) begin
          pc_wr    = 1'b0;
          ifid_wr  = 1'b0;
          idex_bub = 1'b1;
        end
        if (state_q == ST_RSVD) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.iDMemReady) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q >= TO_LIMIT) begin
          // Abandon the access: let the pipeline move with a NOP into WB.
          memwb_bub = 1'b1;
          abort     = 1'b1;
          state_d   = ST_RUN;
          wait_d    = '0;
        end else begin
          {pc_wr, ifid_wr, idex_wr, exmem_wr} = 4'b0000;
          memwb_bub = 1'b1;
          wait_d    = wait_q + WAIT_ONE;
        end
      end
      ST_MD_WAIT: begin
        if (mem_wait) begin
          {pc_wr, ifid_wr, idex_wr, exmem_wr} = 4'b0000;
          memwb_bub = 1'b1;
          state_d   = ST_MEM_WAIT;
          wait_d    = WAIT_ONE;
        end else if (bus.iMdDone) begin
          state_d = ST_RUN;
        end else begin
          {pc_wr, ifid_wr, idex_wr} = 3'b000;
          exmem_bub = 1'b1;
        end
      end
    endcase
  end

  assign timeout_d = bus.iCntClr ? 1'b0 : (timeout_q | abort);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  stall_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (resetn),
    .clr_i (bus.iCntClr),
    .inc_i (~pc_wr),
    .cnt_o (stall_cnt)
  );

  assign bus.oPCWr        = pc_wr;
  assign bus.oIFIDWr      = ifid_wr;
  assign bus.oIFIDFlush   = ifid_flush;
  assign bus.oIDEXWr      = idex_wr;
  assign bus.oIDEXBubble  = idex_bub;
  assign bus.oEXMEMWr     = exmem_wr;
  assign bus.oEXMEMBubble = exmem_bub;
  assign bus.oMEMWBBubble = memwb_bub;
  assign bus.oState       = state_q;
  assign bus.oStallCnt    = stall_cnt;
  assign bus.oTimeout     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pipe_stall_ctrl : scoreboard bench with behavioural model      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_pipe_stall_ctrl;

  localparam int MEM_TIMEOUT = 6;
  localparam int CNT_W       = 6;
  localparam int TO_W        = 3;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  typedef struct packed {
    logic             pc;
    logic             ifid;
    logic             flush;
    logic             idex;
    logic             idexb;
    logic             exmem;
    logic             exmemb;
    logic             memwbb;
    logic [1:0]       st;
    logic [CNT_W-1:0] cnt;
    logic             to;
  } obs_t;

  logic  clk = 1'b0;
  logic  resetn = 1'b0;
  obs_t  exp_q[$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    n_cyc = 0;
  string phase = "reset";

  // Reference model: pipeline mode (0 run, 1 memory wait, 2 mult/div wait)
  int m_mode = 0;
  int m_wait = 0;
  int m_cnt  = 0;
  bit m_to   = 1'b0;

  pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_stall_ctrl #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W),
    .TO_W        (TO_W)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input bit rn, input bit lu, input bit br, input bit ms,
                      input bit md, input bit rq, input bit rd, input bit clr);
    obs_t e;
    bit   mw;
    int   nmode, nwait;
    bit   ab;
    @(posedge clk);
    #1;
    resetn         = rn;
    bus.iLoadUse   = lu;
    bus.iBrTaken   = br;
    bus.iMdStart   = ms;
    bus.iMdDone    = md;
    bus.iDMemReq   = rq;
    bus.iDMemReady = rd;
    bus.iCntClr    = clr;
    if (!rn) begin
      m_mode = 0; m_wait = 0; m_cnt = 0; m_to = 1'b0;
    end
    e = '0;
    {e.pc, e.ifid, e.idex, e.exmem} = 4'b1111;
    e.st  = 2'(m_mode);
    e.cnt = CNT_W'(m_cnt);
    e.to  = m_to;
    mw    = rq && !rd;
    nmode = m_mode;
    nwait = m_wait;
    ab    = 1'b0;
    if (m_mode == 0) begin
      if (mw) begin
        {e.pc, e.ifid, e.idex, e.exmem} = 4'b0000; e.memwbb = 1'b1;
        nmode = 1; nwait = 1;
      end else if (ms && !md) begin
        {e.pc, e.ifid, e.idex} = 3'b000; e.exmemb = 1'b1;
        nmode = 2;
      end else if (br) begin
        e.flush = 1'b1; e.idexb = 1'b1;
      end else if (lu) begin
        e.pc = 1'b0; e.ifid = 1'b0; e.idexb = 1'b1;
      end
    end else if (m_mode == 1) begin
      if (rd) begin
        nmode = 0; nwait = 0;
      end else if (m_wait >= MEM_TIMEOUT) begin
        e.memwbb = 1'b1; ab = 1'b1; nmode = 0; nwait = 0;
      end else begin
        {e.pc, e.ifid, e.idex, e.exmem} = 4'b0000; e.memwbb = 1'b1;
        nwait = m_wait + 1;
      end
    end else begin
      if (mw) begin
        {e.pc, e.ifid, e.idex, e.exmem} = 4'b0000; e.memwbb = 1'b1;
        nmode = 1; nwait = 1;
      end else if (md) begin
        nmode = 0;
      end else begin
        {e.pc, e.ifid, e.idex} = 3'b000; e.exmemb = 1'b1;
      end
    end
    if (rn) begin
      m_mode = nmode;
      m_wait = nwait;
      if (clr) begin
        m_cnt = 0; m_to = 1'b0;
      end else begin
        if (!e.pc && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        if (ab) m_to = 1'b1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin : monitor
    obs_t a;
    obs_t e;
    n_cyc++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {bus.oPCWr, bus.oIFIDWr, bus.oIFIDFlush, bus.oIDEXWr, bus.oIDEXBubble,
           bus.oEXMEMWr, bus.oEXMEMBubble, bus.oMEMWBBubble, bus.oState,
           bus.oStallCnt, bus.oTimeout};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s cyc%0d: got pc=%b ifid=%b fl=%b idex=%b idb=%b exm=%b exb=%b wbb=%b st=%0d cnt=%0d to=%b, expected pc=%b ifid=%b fl=%b idex=%b idb=%b exm=%b exb=%b wbb=%b st=%0d cnt=%0d to=%b",
                 phase, n_cyc, a.pc, a.ifid, a.flush, a.idex, a.idexb, a.exmem, a.exmemb,
                 a.memwbb, a.st, a.cnt, a.to, e.pc, e.ifid, e.flush, e.idex, e.idexb,
                 e.exmem, e.exmemb, e.memwbb, e.st, e.cnt, e.to);
      end
    end
  end

  initial begin
    bus.iLoadUse = 0; bus.iBrTaken = 0; bus.iMdStart = 0; bus.iMdDone = 0;
    bus.iDMemReq = 0; bus.iDMemReady = 0; bus.iCntClr = 0;

    phase = "reset";
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    phase = "load_use";
    step(1, 1, 0, 0, 0, 0, 0, 0);
    idle(2);

    phase = "branch_over_load_use";
    step(1, 1, 1, 0, 0, 0, 0, 0);
    idle(1);

    phase = "mem_wait";
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1, 1, 0);
    idle(2);

    phase = "mem_timeout";
    for (int i = 0; i < MEM_TIMEOUT + 1; i++) step(1, 0, 0, 0, 0, 1, 0, 0);
    idle(2);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    phase = "mult_div";
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0);
    idle(1);

    phase = "md_then_mem";
    step(1, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 1, 1, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0);
    idle(1);

    phase = "reset_in_md_wait";
    step(1, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    phase = "random";
    for (int i = 0; i < 4000; i++) begin
      int p_rd;
      p_rd = (i < 2000) ? 50 : 12;
      step(($urandom_range(199) != 0),
           ($urandom_range(99) < 25), ($urandom_range(99) < 20),
           ($urandom_range(99) < 15), ($urandom_range(99) < 40),
           ($urandom_range(99) < 40), ($urandom_range(99) < p_rd),
           ($urandom_range(99) < 3));
    end
    idle(2);

    @(negedge clk);
    #1;
    phase = "drain";
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
